// File: rtl/wbarbiter_walk.sv
// wbarbiter_walk: two-master, one-slave pipelined Wishbone arbiter that shares
// the LED walker peripheral between the debug bridge (A) and the CPU (B).
//
// Each master holds the slave for a whole bus cycle (CYC). Contention in IDLE is
// resolved round-robin against the last owner. A watchdog aborts a cycle that
// stalls or waits for acks too long. Slave errors go back to the owning master.
//
// Handshake: a request is accepted on a cycle where the owner has stb high and
// its stall low. Each accepted request gets exactly one ack or err from the
// slave. The arbiter adds no latency to the request path once the grant is held.
//
// Ports
//   i_clk, i_reset_n               clock, asynchronous active-low reset
//   i_a_* / o_a_*                  master A request in, stall/ack/err/data out
//   i_b_* / o_b_*                  master B, identical to A
//   o_cyc,o_stb,o_we,o_addr,o_data slave request
//   i_stall,i_ack,i_err,i_data     slave response
//   o_dbg_state                    FSM state (0 IDLE, 1 OWN_A, 2 OWN_B, 3 ABORT)
module wbarbiter_walk #(
  parameter int AW      = 1,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64,
  parameter int LGOUT   = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_a_cyc,
  input  logic          i_a_stb,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_data,
  output logic          o_a_stall,
  output logic          o_a_ack,
  output logic          o_a_err,
  output logic [DW-1:0] o_a_data,
  input  logic          i_b_cyc,
  input  logic          i_b_stb,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_data,
  output logic          o_b_stall,
  output logic          o_b_ack,
  output logic          o_b_err,
  output logic [DW-1:0] o_b_data,
  output logic          o_cyc,
  output logic          o_stb,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  input  logic          i_stall,
  input  logic          i_ack,
  input  logic          i_err,
  input  logic [DW-1:0] i_data,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [LGOUT-1:0] MAX_OUT = '1;
  localparam logic [WDW-1:0]   WD_LAST = WDW'(TIMEOUT - 1);

  state_t           state;
  logic             last_b;   // last owner was B
  logic             owner_b;  // current/aborting owner is B
  logic [LGOUT-1:0] outstanding;
  logic [WDW-1:0]   watchdog;

  logic owner_cyc, owner_stb, active, full, stall;
  logic accept, ack, ack_cnt, wd_inc, err_now;

  always_comb begin
    owner_cyc = owner_b ? i_b_cyc : i_a_cyc;
    owner_stb = owner_b ? i_b_stb : i_a_stb;
    active    = ((state == OWN_A) || (state == OWN_B)) && owner_cyc;
    full      = (outstanding == MAX_OUT);
    stall     = i_stall | full;
    // stb is withheld from the slave while the outstanding limit is reached, so
    // the slave can never take a request the owner believes was stalled.
    o_stb     = active & owner_stb & ~full;
    accept    = o_stb & ~i_stall;
    ack       = active & i_ack;
    ack_cnt   = ack & (outstanding != '0);
    // Waiting on a stalled stb or on owed acks; any progress resets the count.
    wd_inc    = active & ((o_stb & i_stall) | ((outstanding != '0) & ~i_ack))
                & ~accept & ~i_ack;
    err_now   = active & (i_err | (wd_inc & (watchdog == WD_LAST)));
  end

  assign o_cyc       = active;
  assign o_we        = owner_b ? i_b_we   : i_a_we;
  assign o_addr      = owner_b ? i_b_addr : i_a_addr;
  assign o_data      = owner_b ? i_b_data : i_a_data;
  assign o_a_stall   = ~(active & ~owner_b) | stall;
  assign o_b_stall   = ~(active &  owner_b) | stall;
  assign o_a_ack     = ack & ~owner_b;
  assign o_b_ack     = ack &  owner_b;
  assign o_a_err     = err_now & ~owner_b;
  assign o_b_err     = err_now &  owner_b;
  assign o_a_data    = i_data;
  assign o_b_data    = i_data;
  assign o_dbg_state = state;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      last_b      <= 1'b1;
      owner_b     <= 1'b0;
      outstanding <= '0;
      watchdog    <= '0;
    end else begin
      case (state)
        IDLE: begin
          outstanding <= '0;
          watchdog    <= '0;
          if (i_a_cyc && (!i_b_cyc || last_b)) begin
            state   <= OWN_A;
            owner_b <= 1'b0;
          end else if (i_b_cyc) begin
            state   <= OWN_B;
            owner_b <= 1'b1;
          end
        end
        OWN_A, OWN_B: begin
          if (!owner_cyc) begin
            // Always pass through IDLE so a late ack cannot reach the next owner.
            state       <= IDLE;
            last_b      <= owner_b;
            outstanding <= '0;
            watchdog    <= '0;
          end else if (err_now) begin
            state       <= ABORT;
            outstanding <= '0;
            watchdog    <= '0;
          end else begin
            if (accept && !ack_cnt)
              outstanding <= outstanding + 1'b1;
            else if (!accept && ack_cnt)
              outstanding <= outstanding - 1'b1;
            watchdog <= wd_inc ? watchdog + 1'b1 : '0;
          end
        end
        ABORT: begin
          if (!owner_cyc) begin
            state  <= IDLE;
            last_b <= owner_b;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
